// File: rtl/cpu_pkg.sv
// Shared types and default constants for the cpu square-root block.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    ITER,
    WRITE,
    DONE
  } state_t;

  localparam int DM_DEPTH   = 256;
  localparam int OPND_ADDR  = 16;
  localparam int RES_ADDR   = 18;
  localparam int ITER_COUNT = 8;

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: combinational read, synchronous write, single port.
// Core is deliberately left out of reset so preloaded contents survive it.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] Core [0:DEPTH-1];

  assign rdata = Core[addr];

  always_ff @(posedge clk) begin
    if (we) Core[addr] <= wdata;
  end

endmodule

// File: rtl/cpu.sv
// Hardwired integer square root of the 16-bit operand at OPND_ADDR into RES_ADDR.
// Optional macro SQRT_ROUND_EN: store the round-half-up result (saturating) instead of floor.
//
// state    | meaning
// IDLE     | wait for Start to be sampled low
// FETCH_HI | load operand MSB, clear root/rem, load digit count
// FETCH_LO | load operand LSB
// ITER     | one restoring root digit per cycle, count 7..0
// WRITE    | store result byte
// DONE     | Ack high until Start returns high
module cpu
  import cpu_pkg::*;
#(
  parameter int DM_DEPTH  = cpu_pkg::DM_DEPTH,
  parameter int OPND_ADDR = cpu_pkg::OPND_ADDR,
  parameter int RES_ADDR  = cpu_pkg::RES_ADDR
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);

  localparam int AW = $clog2(DM_DEPTH);
  localparam logic [AW-1:0] ADDR_HI  = AW'(OPND_ADDR);
  localparam logic [AW-1:0] ADDR_LO  = AW'(OPND_ADDR + 1);
  localparam logic [AW-1:0] ADDR_RES = AW'(RES_ADDR);
  localparam logic [2:0]    CNT_INIT = 3'(ITER_COUNT - 1);

  state_t state_q, state_d;

  logic [15:0]   opnd;
  logic [8:0]    rem;
  logic [7:0]    root;
  logic [2:0]    cnt;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [1:0]    pair;
  logic [10:0]   r_trial;
  logic [10:0]   t_trial;
  logic [10:0]   r_diff;
  logic          digit;
  logic [8:0]    rem_nxt;
  logic [7:0]    res;

  data_mem #(
    .DEPTH (DM_DEPTH),
    .AW    (AW)
  ) DM1 (
    .clk   (Clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Remainder stays below 2*root+1 <= 511, so 9 bits always hold it.
  always_comb begin
    pair    = opnd[{cnt, 1'b0} +: 2];
    r_trial = {rem, pair};
    t_trial = {1'b0, root, 2'b01};
    r_diff  = r_trial - t_trial;
    digit   = (r_trial >= t_trial);
    rem_nxt = digit ? r_diff[8:0] : r_trial[8:0];
  end

`ifdef SQRT_ROUND_EN
  always_comb begin
    res = root;
    if ((root != 8'hFF) && (rem > {1'b0, root})) res = root + 8'd1;
  end
`else
  assign res = root;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_addr  = ADDR_HI;
    mem_wdata = res;
    Ack       = 1'b0;
    case (state_q)
      IDLE:     if (!Start) state_d = FETCH_HI;
      FETCH_HI: state_d = FETCH_LO;
      FETCH_LO: begin
        mem_addr = ADDR_LO;
        state_d  = ITER;
      end
      ITER:     if (cnt == 3'd0) state_d = WRITE;
      WRITE: begin
        mem_addr = ADDR_RES;
        mem_we   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        Ack = 1'b1;
        if (Start) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      opnd <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
    end else begin
      case (state_q)
        FETCH_HI: begin
          opnd[15:8] <= mem_rdata;
          rem        <= '0;
          root       <= '0;
          cnt        <= CNT_INIT;
        end
        FETCH_LO: opnd[7:0] <= mem_rdata;
        ITER: begin
          rem  <= rem_nxt;
          root <= {root[6:0], digit};
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu: square-root results, latency, handshake, resets.
module tb_cpu;

  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Ack;

  int n_chk = 0;
  int n_err = 0;

  cpu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Preload operand, launch, count edges to Ack, check result byte.
  task automatic run_op(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                        input int exp_floor, input int exp_round, input bit glitch);
    int edges;
    int exp;
`ifdef SQRT_ROUND_EN
    exp = exp_round;
`else
    exp = exp_floor;
`endif
    @(negedge Clk);
    Start = 1'b1;
    dut.DM1.Core[16] = hi;
    dut.DM1.Core[17] = lo;
    dut.DM1.Core[18] = 8'hEE;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    edges = 0;
    do begin
      @(posedge Clk);
      #1;
      edges++;
      if (glitch && edges == 5) Start = 1'b1;
      if (glitch && edges == 6) Start = 1'b0;
    end while (!Ack && edges < 40);
    chk({tag, "_lat"}, edges, 12);
    chk({tag, "_res"}, int'(dut.DM1.Core[18]), exp);
  endtask

  task automatic finish_op(input string tag);
    repeat (3) @(posedge Clk);
    #1;
    chk({tag, "_hold"}, int'(Ack), 1);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    chk({tag, "_drop"}, int'(Ack), 0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_ack", int'(Ack), 0);
    @(negedge Clk);
    Reset = 1'b0;

    run_op("sq36864", 8'h90, 8'h00, 192, 192, 1'b0); finish_op("sq36864");
    run_op("max",     8'hFF, 8'hFF, 255, 255, 1'b0); finish_op("max");
    run_op("zero",    8'h00, 8'h00, 0,   0,   1'b0); finish_op("zero");
    run_op("one",     8'h00, 8'h01, 1,   1,   1'b0); finish_op("one");
    run_op("n24",     8'h00, 8'd24, 4,   5,   1'b0); finish_op("n24");
    run_op("n255",    8'h00, 8'hFF, 15,  16,  1'b1); finish_op("n255");
    run_op("n256",    8'h01, 8'h00, 16,  16,  1'b0); finish_op("n256");
    run_op("n3",      8'h00, 8'h03, 1,   2,   1'b0); finish_op("n3");

    // Reset during ITER: abort without writing the result byte.
    @(negedge Clk);
    dut.DM1.Core[16] = 8'h00;
    dut.DM1.Core[17] = 8'd100;
    dut.DM1.Core[18] = 8'h33;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("midrst_ack", int'(Ack), 0);
    Start = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    chk("midrst_idle", int'(Ack), 0);
    chk("midrst_res", int'(dut.DM1.Core[18]), 8'h33);
    chk("midrst_lsb", int'(dut.DM1.Core[17]), 100);

    // Rerun, then reset asynchronously while sitting in DONE.
    run_op("n100", 8'h00, 8'd100, 10, 10, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    chk("donerst_ack", int'(Ack), 0);
    Start = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;

    run_op("n144", 8'h00, 8'd144, 12, 12, 1'b0); finish_op("n144");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
